// File: rtl/wrr_lock_arbiter_4.sv
// Four-input weighted round-robin arbiter with burst locking in front of a
// shared ready/valid sink. Datapath is combinational; only grant state is held.
module wrr_lock_arbiter_4 #(
  parameter int WIDTH = 8,
  parameter int WBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_0_valid,
  output logic             io_in_0_ready,
  input  logic [WIDTH-1:0] io_in_0_bits,
  input  logic             io_in_1_valid,
  output logic             io_in_1_ready,
  input  logic [WIDTH-1:0] io_in_1_bits,
  input  logic             io_in_2_valid,
  output logic             io_in_2_ready,
  input  logic [WIDTH-1:0] io_in_2_bits,
  input  logic             io_in_3_valid,
  output logic             io_in_3_ready,
  input  logic [WIDTH-1:0] io_in_3_bits,
  input  logic [WBITS-1:0] io_weight_0,
  input  logic [WBITS-1:0] io_weight_1,
  input  logic [WBITS-1:0] io_weight_2,
  input  logic [WBITS-1:0] io_weight_3,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic [1:0]       io_chosen,
  output logic             io_locked
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           r_state, w_stateNext;
  logic [1:0]       r_owner, w_ownerNext;
  logic [1:0]       r_ptr, w_ptrNext;
  logic [WBITS-1:0] r_cnt, w_cntNext;
  logic [WBITS-1:0] r_wlat, w_wlatNext;

  logic [3:0]       w_valid;
  logic [WIDTH-1:0] w_bits [4];
  logic [WBITS-1:0] w_weight [4];
  logic [1:0]       w_scan;
  logic [1:0]       w_idx;
  logic             w_found;
  logic [1:0]       w_chosen;
  logic             w_outValid;
  logic             w_xfer;
  logic [WBITS-1:0] w_wEff;
  logic [WBITS-1:0] w_cntInc;

  assign w_valid     = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
  assign w_bits[0]   = io_in_0_bits;
  assign w_bits[1]   = io_in_1_bits;
  assign w_bits[2]   = io_in_2_bits;
  assign w_bits[3]   = io_in_3_bits;
  assign w_weight[0] = io_weight_0;
  assign w_weight[1] = io_weight_1;
  assign w_weight[2] = io_weight_2;
  assign w_weight[3] = io_weight_3;

  // Rotating scan starts just after the last completed owner; ptr itself is checked last.
  always_comb begin
    w_scan  = r_ptr + 2'd1;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_valid[w_idx]) begin
        w_scan  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_chosen   = (r_state == ST_LOCKED) ? r_owner : w_scan;
  assign w_outValid = (r_state == ST_LOCKED) ? w_valid[r_owner] : |w_valid;
  assign w_xfer     = w_outValid && io_out_ready;
  assign w_wEff     = (w_weight[w_chosen] == '0) ? WBITS'(1) : w_weight[w_chosen];
  assign w_cntInc   = r_cnt + WBITS'(1);

  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_ptrNext   = r_ptr;
    w_cntNext   = r_cnt;
    w_wlatNext  = r_wlat;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_wlatNext = w_wEff;
          if (w_wEff == WBITS'(1)) begin
            w_ptrNext = w_chosen;
          end else begin
            w_stateNext = ST_LOCKED;
            w_ownerNext = w_chosen;
            w_cntNext   = WBITS'(1);
          end
        end
      end
      ST_LOCKED: begin
        // An owner that drops valid mid-burst forfeits the rest of its burst.
        if (!w_valid[r_owner]) begin
          w_stateNext = ST_IDLE;
          w_ptrNext   = r_owner;
          w_cntNext   = '0;
        end else if (io_out_ready) begin
          w_cntNext = w_cntInc;
          if (w_cntInc == r_wlat) begin
            w_stateNext = ST_IDLE;
            w_ptrNext   = r_owner;
          end
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd3;
      r_cnt   <= '0;
      r_wlat  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_owner <= w_ownerNext;
      r_ptr   <= w_ptrNext;
      r_cnt   <= w_cntNext;
      r_wlat  <= w_wlatNext;
    end
  end

  assign io_out_valid  = w_outValid;
  assign io_out_bits   = w_bits[w_chosen];
  assign io_chosen     = w_chosen;
  assign io_locked     = (r_state == ST_LOCKED);
  assign io_in_0_ready = io_out_ready && (w_chosen == 2'd0) && (r_state == ST_IDLE || r_owner == 2'd0);
  assign io_in_1_ready = io_out_ready && (w_chosen == 2'd1) && (r_state == ST_IDLE || r_owner == 2'd1);
  assign io_in_2_ready = io_out_ready && (w_chosen == 2'd2) && (r_state == ST_IDLE || r_owner == 2'd2);
  assign io_in_3_ready = io_out_ready && (w_chosen == 2'd3) && (r_state == ST_IDLE || r_owner == 2'd3);

endmodule

// File: doc/wrr_lock_arbiter_4.md
# wrr_lock_arbiter_4

Four-input weighted round-robin arbiter with burst locking, placed in front of a shared 8-bit ready/valid sink. It extends the plain round-robin arbiter with these features:
- Each requester has a configurable weight.
- Once granted, a requester keeps the output for up to that many consecutive beats. Other requesters cannot interleave during that burst.
- Fairness is restored by a rotating priority pointer.

The datapath stays combinational; only grant state is registered.

## Interface
Parameters:
- WIDTH, 8, payload width of every input and of the output
- WBITS, 3, width of each weight field (max burst = 2^WBITS − 1 beats)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- io_in_N_valid  input  1  (N = 0..3) requester N has a beat
- io_in_N_ready  output  1  beat from N accepted this cycle
- io_in_N_bits  input  WIDTH  payload of requester N
- io_weight_N  input  WBITS  burst length for requester N; 0 is treated as 1
- io_out_valid  output  1  beat presented to sink
- io_out_ready  input  1  sink accepts
- io_out_bits  output  WIDTH  payload of granted requester
- io_chosen  output  2  index currently selected
- io_locked  output  1  high while in LOCKED state

## Operation
Registered state:
- state (IDLE/LOCKED)
- owner[1:0]
- ptr[1:0], the last completed owner
- cnt[WBITS-1:0], beats sent in the current burst
- wlat[WBITS-1:0], the latched weight

Reset values: state=IDLE, owner=0, ptr=3, cnt=0, wlat=0.

IDLE:
- chosen = the first valid input scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
- If no input is valid, chosen = ptr+1 mod 4.
- io_out_valid = OR of all valids.
- Transfer = io_out_valid && io_out_ready. On a transfer:
  - Latch wlat = max(io_weight_chosen, 1).
  - If wlat == 1: stay IDLE and set ptr = chosen.
  - Otherwise: go LOCKED with owner = chosen, cnt = 1.
- No transfer: no state change. Grant may change freely while the sink stalls; there is no lock before the first beat.

LOCKED:
- chosen = owner. io_out_valid = io_in_owner_valid. Other inputs see ready = 0.
- Transfer: cnt += 1. If cnt+1 == wlat, go IDLE and set ptr = owner.
- Owner valid low: release. Go IDLE, ptr = owner, cnt = 0. No beat moves in that cycle. Arbitration resumes the next cycle.
- Owner valid high, sink not ready: hold all state.

Common rules:
- io_in_N_ready = io_out_ready && (chosen == N) && (state == IDLE || owner == N).
- io_out_bits = io_in_chosen_bits.
- io_locked = (state == LOCKED).
- Weight inputs are sampled only on the first beat of a burst. Changes mid-burst take effect on the next grant.
- cnt never wraps: wlat ≤ 2^WBITS − 1 and the exit occurs at cnt+1 == wlat.

## Timing
- Zero-cycle latency: payload and valid pass combinationally from the selected input to the output. The ready path is combinational from io_out_ready.
- State updates on the rising clk edge after a transfer or release.
- Reset mid-burst: all outputs return to IDLE arbitration immediately, asynchronously. The next grant scans from input 0.
- A burst of weight W occupies exactly W transfer cycles plus any sink stall cycles. The next requester can be granted in the cycle after the last beat.
- Valid/ready contract on inputs: a requester must not drop valid while stalled. If it does anyway while locked, this is handled as a release, not an error.

## Test plan
- Reset, then inputs 0–3 all valid, weights all 1, out_ready=1 → io_chosen sequence 0,1,2,3,0; exactly one ready high per cycle.
- Weight_1=3, all valid, ptr=0 → input 1 gets three consecutive beats, io_locked=1 on beats 2–3, then input 2 is granted next cycle.
- Locked on input 2 (weight 4, cnt=2), input 2 drops valid → io_out_valid=0 that cycle, io_locked falls, next grant goes to 3 if valid.
- Locked burst with out_ready low for 5 cycles → cnt, owner and io_out_bits are stable; other readies stay 0; the burst completes with the correct beat count afterwards.
- Weight 0 on input 3, only input 3 valid → single-beat grants, io_locked never asserts.
- Assert reset asynchronously mid-burst (weight 7, cnt=3) → io_locked drops without a clock edge; after release, input 0 wins when all inputs are valid.
